plights_ctrl: RTL and testbench
===============================

# plights_ctrl

Run-time controller for the 8-bit LED pattern datapath. It owns the prescaler and pattern state and accepts mode/speed commands from a host over a valid/ready handshake. It also supports pause/resume and drives `led` with one of four sequenced patterns. It sits between a host or CSR block and the board LEDs, and replaces fixed-divider pattern generation with a reconfigurable one.

## Interface
- `DIV_W`, 16: prescaler width in bits.
- `DEFAULT_DIV`, 2: divider value loaded at reset. Must be < 2^DIV_W.

- `clk`  in  1  system clock; all state updates on rising edge.
- `rst`  in  1  reset, asynchronous, active-low. Asserting it low clears all state immediately; release is synchronous to `clk`.
- `cmd_valid`  in  1  host command present.
- `cmd_ready`  out  1  controller can accept a command.
- `cmd_mode`  in  2  requested mode: 0 OFF, 1 SHIFT, 2 BOUNCE, 3 COUNT.
- `cmd_div`  in  DIV_W  requested pattern period in `clk` cycles; 0 is treated as 1.
- `pause`  in  1  level; freezes the pattern while high.
- `led`  out  8  LED drive, registered.
- `step`  out  1  one-cycle pulse, coincident with each new `led` value from a prescaler tick.
- `busy`  out  1  high whenever state ≠ IDLE.

## Operation
- States:
  - IDLE: mode OFF, `led`=0.
  - LOAD: one cycle.
  - RUN.
  - PAUSED.
- Command acceptance:
  - Handshake completes on a rising edge with `cmd_valid & cmd_ready`.
  - `cmd_ready`=1 in IDLE, RUN and PAUSED; 0 in LOAD.
  - `cmd_mode` and `cmd_div` are latched at acceptance into `mode_q` and `div_q`. `div_q` = max(`cmd_div`,1).
- LOAD:
  - Sets `led` to the initial value: OFF 0x00, SHIFT 0x01, BOUNCE 0x01 with dir=up, COUNT 0x00.
  - Clears the prescaler count `cnt` to 0. `step`=0.
  - Exits to IDLE if `mode_q`=OFF. Otherwise exits to PAUSED if `pause`=1, else RUN.
- RUN:
  - `cnt` increments every cycle.
  - When `cnt`==`div_q`−1: `cnt`←0, `step`←1, `led`←next(`led`). Otherwise `step`←0.
  - If `pause`=1: go to PAUSED, `cnt` and `led` hold, and no tick occurs on that edge.
- PAUSED:
  - `cnt`, `led` and dir hold; `step`=0.
  - `pause`=0 returns to RUN, which resumes counting from the held `cnt`.
- next() by mode:
  - SHIFT: rotate left, wrapping 0x80→0x01.
  - BOUNCE: n = dir_up ? `led`<<1 : `led`>>1. If n==0x80, dir←down; if n==0x01, dir←up.
  - COUNT: `led`+1 modulo 256, wrapping 0xFF→0x00.
- A new command is accepted in RUN or PAUSED at any time. It discards the current pattern position and `cnt`.

## Timing
- Reset values (while `rst`=0):
  - `led`=0x00, `step`=0, `cmd_ready`=1, `busy`=0.
  - State IDLE, `mode_q`=OFF, `div_q`=max(`DEFAULT_DIV`,1), `cnt`=0, dir=up.
- Command latency:
  - Accept at edge E0 → LOAD is active during cycle E0..E1.
  - At E1, `led` shows the initial value and the state becomes RUN.
  - The first `step` occurs at edge E1+`div_q`.
- Tick spacing: `step` pulses exactly every `div_q` cycles in RUN. `div_q`=1 gives `step` high continuously and `led` updates every cycle.
- Simultaneous events:
  - Tick and command acceptance on the same edge: the tick updates `led`, then LOAD overwrites it on the next edge.
  - `pause` and `cmd_valid` in PAUSED: the command is accepted, and LOAD exits to PAUSED if `pause` is still high.
  - `pause` rising on a tick edge: the pause wins and no tick occurs.
- Reset asserted mid-pattern: all outputs take their reset values immediately, without waiting for a clock. An in-flight command is lost.
- `cmd_mode`/`cmd_div` are sampled only on an accepting edge; values at other times are ignored.

## Test plan
- Reset: hold `rst`=0 for 3 cycles, release → `led`=0x00, `cmd_ready`=1, `busy`=0, `step`=0. Assert `rst`=0 asynchronously mid-RUN → `led` goes to 0x00 before the next `clk` edge.
- SHIFT, `cmd_div`=2:
  - `led` sequence 01,02,04,…,80,01.
  - `step` pulses every 2 cycles.
  - First `step` 2 cycles after LOAD.
  - `cmd_ready` low for exactly one cycle after acceptance.
- BOUNCE, `cmd_div`=1: 10 consecutive values are 02,04,08,10,20,40,80,40,20,10.
- COUNT, `cmd_div`=0 (treated as 1): `step` constant high and `led` increments every cycle. Preload by running 255 ticks from 0x00 → 0xFF then 0x00 on the next tick.
- Pause: COUNT with `cmd_div`=4; assert `pause` for 10 cycles at `cnt`=2 → `led` and `step` frozen. After release, the next `step` comes 2 cycles later.
- Re-command: mid-SHIFT at `led`=0x10, issue BOUNCE with `cmd_div`=3 → `led`=0x01 one cycle after acceptance, then 0x02 three cycles later. Issue OFF → `led`=0x00 and `busy`=0.

Source files
------------

// File: rtl/plights_ctrl.sv
// Run-time LED pattern controller: host-programmable mode and period,
// pause/resume, and a registered 8-bit LED drive with a per-tick strobe.
module plights_ctrl #(
  parameter int DIV_W       = 16,
  parameter int DEFAULT_DIV = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_mode,
  input  logic [DIV_W-1:0] cmd_div,
  input  logic             pause,
  output logic [7:0]       led,
  output logic             step,
  output logic             busy
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_RUN    = 2'd2,
    ST_PAUSED = 2'd3
  } state_t;

  localparam logic [1:0] MODE_OFF    = 2'd0;
  localparam logic [1:0] MODE_SHIFT  = 2'd1;
  localparam logic [1:0] MODE_BOUNCE = 2'd2;
  localparam logic [1:0] MODE_COUNT  = 2'd3;

  localparam logic [DIV_W-1:0] DIV_ZERO = {DIV_W{1'b0}};
  localparam logic [DIV_W-1:0] DIV_ONE  = {{(DIV_W-1){1'b0}}, 1'b1};
  localparam logic [DIV_W-1:0] DIV_RST  = (DEFAULT_DIV < 32'sd1) ? DIV_ONE : DIV_W'(DEFAULT_DIV);

  // Returns {dir_up, led} after one pattern advance.
  function automatic logic [8:0] next_pat(input logic [1:0] mode, input logic [7:0] cur,
                                          input logic up);
    logic [7:0] n;
    logic       d;
    n = cur;
    d = up;
    case (mode)
      MODE_SHIFT:  n = {cur[6:0], cur[7]};
      MODE_BOUNCE: begin
        n = up ? {cur[6:0], 1'b0} : {1'b0, cur[7:1]};
        if (n == 8'h80) d = 1'b0;
        else if (n == 8'h01) d = 1'b1;
        else d = up;
      end
      MODE_COUNT:  n = cur + 8'd1;
      default:     n = cur;
    endcase
    return {d, n};
  endfunction

  function automatic logic [7:0] init_pat(input logic [1:0] mode);
    case (mode)
      MODE_SHIFT:  return 8'h01;
      MODE_BOUNCE: return 8'h01;
      default:     return 8'h00;
    endcase
  endfunction

  state_t           state_r, state_s;
  logic [1:0]       mode_r, mode_s;
  logic [DIV_W-1:0] div_r, div_s;
  logic [DIV_W-1:0] cnt_r, cnt_s;
  logic [7:0]       led_r, led_s;
  logic             dir_up_r, dir_up_s;
  logic             step_r, step_s;
  logic             ready_r, ready_s;
  logic             busy_r, busy_s;
  logic             accept_s;
  logic             tick_s;
  logic [8:0]       pat_s;

  // Next-state, pattern and handshake logic; a command always wins over the current state.
  always_comb begin
    state_s  = state_r;
    mode_s   = mode_r;
    div_s    = div_r;
    cnt_s    = cnt_r;
    led_s    = led_r;
    dir_up_s = dir_up_r;
    step_s   = 1'b0;
    accept_s = cmd_valid & ready_r;
    tick_s   = (cnt_r == (div_r - DIV_ONE));
    pat_s    = next_pat(mode_r, led_r, dir_up_r);

    case (state_r)
      ST_IDLE: state_s = ST_IDLE;
      ST_LOAD: begin
        led_s    = init_pat(mode_r);
        cnt_s    = DIV_ZERO;
        dir_up_s = 1'b1;
        if (mode_r == MODE_OFF) state_s = ST_IDLE;
        else if (pause) state_s = ST_PAUSED;
        else state_s = ST_RUN;
      end
      // A paused controller released this cycle counts on the same edge.
      ST_RUN, ST_PAUSED: begin
        if (pause) begin
          state_s = ST_PAUSED;
        end else begin
          state_s = ST_RUN;
          if (tick_s) begin
            cnt_s    = DIV_ZERO;
            step_s   = 1'b1;
            led_s    = pat_s[7:0];
            dir_up_s = pat_s[8];
          end else begin
            cnt_s = cnt_r + DIV_ONE;
          end
        end
      end
      default: state_s = ST_IDLE;
    endcase

    if (accept_s) begin
      state_s = ST_LOAD;
      mode_s  = cmd_mode;
      div_s   = (cmd_div == DIV_ZERO) ? DIV_ONE : cmd_div;
    end else begin
      mode_s = mode_r;
      div_s  = div_r;
    end

    ready_s = (state_s != ST_LOAD);
    busy_s  = (state_s != ST_IDLE);
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r  <= ST_IDLE;
      mode_r   <= MODE_OFF;
      div_r    <= DIV_RST;
      cnt_r    <= DIV_ZERO;
      led_r    <= 8'h00;
      dir_up_r <= 1'b1;
      step_r   <= 1'b0;
      ready_r  <= 1'b1;
      busy_r   <= 1'b0;
    end else begin
      state_r  <= state_s;
      mode_r   <= mode_s;
      div_r    <= div_s;
      cnt_r    <= cnt_s;
      led_r    <= led_s;
      dir_up_r <= dir_up_s;
      step_r   <= step_s;
      ready_r  <= ready_s;
      busy_r   <= busy_s;
    end
  end

  assign cmd_ready = ready_r;
  assign led       = led_r;
  assign step      = step_r;
  assign busy      = busy_r;

endmodule

// File: tb/tb_plights_ctrl.sv
// Directed self-checking bench for plights_ctrl: reset, each pattern mode,
// pause/resume, re-command, and tick/command collision.
module tb_plights_ctrl;

  logic        clk;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_mode;
  logic [15:0] cmd_div;
  logic        pause;
  logic [7:0]  led;
  logic        step;
  logic        busy;

  int checks;
  int errors;

  plights_ctrl #(.DIV_W(16), .DEFAULT_DIV(2)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_mode(cmd_mode), .cmd_div(cmd_div), .pause(pause),
    .led(led), .step(step), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  // Called on a falling edge; returns on the falling edge after the accepting edge.
  task automatic send_cmd(input logic [1:0] m, input logic [15:0] d);
    cmd_valid = 1'b1;
    cmd_mode  = m;
    cmd_div   = d;
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_mode  = 2'd0;
    cmd_div   = 16'd0;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (led !== 8'h00) begin errors++; $display("FAIL reset_led: got %h expected 00", led); end
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", cmd_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (step !== 1'b0) begin errors++; $display("FAIL reset_step: got %b expected 0", step); end
    rst = 1'b1;
    @(negedge clk);
    checks++; if ({led, cmd_ready, busy, step} !== {8'h00, 1'b1, 1'b0, 1'b0}) begin
      errors++; $display("FAIL post_reset_idle: got led=%h rdy=%b busy=%b step=%b", led, cmd_ready, busy, step);
    end
  endtask

  task automatic test_shift;
    logic [7:0] e;
    send_cmd(2'd1, 16'd2);
    checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL shift_ready_load: got %b expected 0", cmd_ready); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL shift_busy_load: got %b expected 1", busy); end
    @(negedge clk);
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL shift_ready_run: got %b expected 1", cmd_ready); end
    checks++; if (led !== 8'h01 || step !== 1'b0) begin errors++; $display("FAIL shift_init: got led=%h step=%b expected 01/0", led, step); end
    e = 8'h01;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checks++; if (led !== e || step !== 1'b0) begin errors++; $display("FAIL shift_hold[%0d]: got led=%h step=%b expected %h/0", i, led, step, e); end
      e = {e[6:0], e[7]};
      @(negedge clk);
      checks++; if (led !== e || step !== 1'b1) begin errors++; $display("FAIL shift_tick[%0d]: got led=%h step=%b expected %h/1", i, led, step, e); end
    end
  endtask

  task automatic test_bounce;
    logic [7:0] tbl [10];
    tbl = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h40, 8'h20, 8'h10};
    send_cmd(2'd2, 16'd1);
    @(negedge clk);
    checks++; if (led !== 8'h01) begin errors++; $display("FAIL bounce_init: got %h expected 01", led); end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++; if (led !== tbl[i] || step !== 1'b1) begin errors++; $display("FAIL bounce[%0d]: got led=%h step=%b expected %h/1", i, led, step, tbl[i]); end
    end
  endtask

  task automatic test_count;
    logic [7:0] e;
    send_cmd(2'd3, 16'd0);
    @(negedge clk);
    checks++; if (led !== 8'h00) begin errors++; $display("FAIL count_init: got %h expected 00", led); end
    e = 8'h00;
    for (int i = 1; i <= 256; i++) begin
      e = e + 8'd1;
      @(negedge clk);
      checks++; if (led !== e || step !== 1'b1) begin errors++; $display("FAIL count[%0d]: got led=%h step=%b expected %h/1", i, led, step, e); end
    end
  endtask

  task automatic test_pause;
    send_cmd(2'd3, 16'd4);
    @(negedge clk);
    checks++; if (led !== 8'h00) begin errors++; $display("FAIL pause_init: got %h expected 00", led); end
    repeat (2) @(negedge clk);
    checks++; if (step !== 1'b0) begin errors++; $display("FAIL pause_prestep: got %b expected 0", step); end
    pause = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++; if (led !== 8'h00 || step !== 1'b0 || busy !== 1'b1) begin
        errors++; $display("FAIL pause_frozen[%0d]: got led=%h step=%b busy=%b expected 00/0/1", i, led, step, busy);
      end
    end
    pause = 1'b0;
    @(negedge clk);
    checks++; if (led !== 8'h00 || step !== 1'b0) begin errors++; $display("FAIL pause_resume1: got led=%h step=%b expected 00/0", led, step); end
    @(negedge clk);
    checks++; if (led !== 8'h01 || step !== 1'b1) begin errors++; $display("FAIL pause_resume2: got led=%h step=%b expected 01/1", led, step); end
  endtask

  task automatic test_recmd;
    send_cmd(2'd1, 16'd2);
    @(negedge clk);
    repeat (8) @(negedge clk);
    checks++; if (led !== 8'h10) begin errors++; $display("FAIL recmd_shift_pos: got %h expected 10", led); end
    send_cmd(2'd2, 16'd3);
    checks++; if (cmd_ready !== 1'b0 || led !== 8'h10) begin errors++; $display("FAIL recmd_load: got rdy=%b led=%h expected 0/10", cmd_ready, led); end
    @(negedge clk);
    checks++; if (led !== 8'h01) begin errors++; $display("FAIL recmd_bounce_init: got %h expected 01", led); end
    repeat (2) @(negedge clk);
    checks++; if (led !== 8'h01 || step !== 1'b0) begin errors++; $display("FAIL recmd_hold: got led=%h step=%b expected 01/0", led, step); end
    @(negedge clk);
    checks++; if (led !== 8'h02 || step !== 1'b1) begin errors++; $display("FAIL recmd_tick: got led=%h step=%b expected 02/1", led, step); end
    send_cmd(2'd0, 16'd5);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL off_busy_load: got %b expected 1", busy); end
    @(negedge clk);
    checks++; if (led !== 8'h00 || busy !== 1'b0 || cmd_ready !== 1'b1) begin
      errors++; $display("FAIL off_idle: got led=%h busy=%b rdy=%b expected 00/0/1", led, busy, cmd_ready);
    end
  endtask

  task automatic test_back_to_back;
    send_cmd(2'd1, 16'd1);
    @(negedge clk);
    @(negedge clk);
    checks++; if (led !== 8'h02 || step !== 1'b1) begin errors++; $display("FAIL b2b_shift: got led=%h step=%b expected 02/1", led, step); end
    send_cmd(2'd3, 16'd1);
    checks++; if (led !== 8'h04 || step !== 1'b1) begin errors++; $display("FAIL b2b_tick_on_accept: got led=%h step=%b expected 04/1", led, step); end
    @(negedge clk);
    checks++; if (led !== 8'h00 || step !== 1'b0) begin errors++; $display("FAIL b2b_load: got led=%h step=%b expected 00/0", led, step); end
    @(negedge clk);
    checks++; if (led !== 8'h01 || step !== 1'b1) begin errors++; $display("FAIL b2b_count: got led=%h step=%b expected 01/1", led, step); end
  endtask

  task automatic test_async_reset;
    send_cmd(2'd1, 16'd1);
    repeat (3) @(negedge clk);
    checks++; if (led !== 8'h04) begin errors++; $display("FAIL areset_pre: got %h expected 04", led); end
    #2;
    rst = 1'b0;
    #1;
    checks++; if ({led, step, busy, cmd_ready} !== {8'h00, 1'b0, 1'b0, 1'b1}) begin
      errors++; $display("FAIL areset_immediate: got led=%h step=%b busy=%b rdy=%b", led, step, busy, cmd_ready);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++; if (led !== 8'h00 || busy !== 1'b0) begin errors++; $display("FAIL areset_idle: got led=%h busy=%b expected 00/0", led, busy); end
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst       = 1'b0;
    cmd_valid = 1'b0;
    cmd_mode  = 2'd0;
    cmd_div   = 16'd0;
    pause     = 1'b0;
    @(negedge clk);
    test_reset();
    test_shift();
    test_bounce();
    test_count();
    test_pause();
    test_recmd();
    test_back_to_back();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
